// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem wait/timeout FSM.
// Latency: stall/flush outputs are combinational (same cycle); mem_timeout registered.
// Backpressure: mem_wait freezes PC..EX/MEM and bubbles MEM/WB; HALT holds until rst.
// Optional perf counters (stall_cycles, flush_events) enabled by macro PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [1:0] LOAD_SEL    = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        global_en,
    input  logic [4:0]  id_rf_ra0,
    input  logic [4:0]  id_rf_ra1,
    input  logic        id_re0,
    input  logic        id_re1,
    input  logic [4:0]  ex_rf_wa,
    input  logic        ex_rf_we,
    input  logic [1:0]  ex_rf_wd_sel,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_mem_wb,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    logic mem_wait;
    logic load_use;
    logic src0_hit;
    logic src1_hit;

    assign mem_wait = mem_req & ~mem_ready;
    assign src0_hit = id_re0 & (id_rf_ra0 == ex_rf_wa);
    assign src1_hit = id_re1 & (id_rf_ra1 == ex_rf_wa);
    // x0 is never a real dependency since it always reads as zero.
    assign load_use = ex_rf_we & (ex_rf_wd_sel == LOAD_SEL) & (ex_rf_wa != 5'd0)
                    & (src0_hit | src1_hit);

    assign mem_timeout = mem_timeout_q;

    // Stall/flush decode by priority: HALT, mem wait, taken branch, load-use.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        if (!rst && global_en) begin
            if (state_q == HALT || mem_wait) begin
                // EX is frozen here, so a pending branch is replayed once dmem completes.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (ex_br_taken) begin
                // The ID instruction is wrong-path, so any load-use it shows is moot.
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    // Next-state for the dmem wait FSM and its timeout counter.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mem_timeout_d = mem_timeout_q;
        if (global_en) begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_wait) begin
                        state_d = RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        state_d       = HALT;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    // FSM state, wait counter and timeout flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating perf counters; outputs are already gated by global_en.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (global_en && stall_pc && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((flush_if_id || flush_id_ex) && flush_events_q != 32'hFFFF_FFFF) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 32'h0;
    assign flush_events = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expected outputs.
// Inputs change 1ns after posedge; outputs sampled 2ns later, well clear of edges.
// Output vector packing: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb, mem_timeout}.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        global_en;
    logic [4:0]  id_rf_ra0;
    logic [4:0]  id_rf_ra1;
    logic        id_re0;
    logic        id_re1;
    logic [4:0]  ex_rf_wa;
    logic        ex_rf_we;
    logic [1:0]  ex_rf_wd_sel;
    logic        ex_br_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_mem_wb;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_0100;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] FULL = 8'b1111_0010;
    localparam logic [7:0] HLT  = 8'b1111_0011;

    int n_vec;
    int n_miss;
    int exp_sc;
    int exp_fe;

    logic [7:0] outs;
    assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                   flush_if_id, flush_id_ex, flush_mem_wb, mem_timeout};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .LOAD_SEL(2'b10)) dut (
        .clk          (clk),
        .rst          (rst),
        .global_en    (global_en),
        .id_rf_ra0    (id_rf_ra0),
        .id_rf_ra1    (id_rf_ra1),
        .id_re0       (id_re0),
        .id_re1       (id_re1),
        .ex_rf_wa     (ex_rf_wa),
        .ex_rf_we     (ex_rf_we),
        .ex_rf_wd_sel (ex_rf_wd_sel),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_mem_wb (flush_mem_wb),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        chk({tag, "_stall_cycles"}, stall_cycles, 32'(exp_sc));
        chk({tag, "_flush_events"}, flush_events, 32'(exp_fe));
`else
        chk({tag, "_stall_cycles"}, stall_cycles, 32'h0);
        chk({tag, "_flush_events"}, flush_events, 32'h0);
`endif
    endtask

    task automatic idle();
        global_en    = 1'b1;
        id_rf_ra0    = 5'd0;
        id_rf_ra1    = 5'd0;
        id_re0       = 1'b0;
        id_re1       = 1'b0;
        ex_rf_wa     = 5'd0;
        ex_rf_we     = 1'b0;
        ex_rf_wd_sel = 2'b00;
        ex_br_taken  = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    // EX holds lw x5; ID reads x5 on port 0.
    task automatic set_load_use();
        ex_rf_we     = 1'b1;
        ex_rf_wd_sel = 2'b10;
        ex_rf_wa     = 5'd5;
        id_rf_ra0    = 5'd5;
        id_re0       = 1'b1;
    endtask

    // Called 1ns after posedge: sample, update the counter model, advance one cycle.
    task automatic vec(input string tag, input logic [7:0] exp);
        #2;
        chk(tag, {24'h0, outs}, {24'h0, exp});
        if (exp[7]) exp_sc++;
        if (exp[3] | exp[2]) exp_fe++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        exp_sc = 0;
        exp_fe = 0;
        rst    = 1'b1;
        idle();
        set_load_use();
        ex_br_taken = 1'b1;
        mem_req     = 1'b1;
        #2;
        chk("rst_outputs", {24'h0, outs}, {24'h0, NONE});
        chk_perf("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        vec("idle", NONE);
        chk_perf("after_rst");

        // Load-use: one bubble, then the NOP in EX clears it.
        set_load_use();
        vec("load_use_ra0", LU);
        ex_rf_we = 1'b0;
        vec("load_use_bubble_done", NONE);
        chk_perf("load_use");

        // x0 never creates a hazard.
        set_load_use();
        ex_rf_wa  = 5'd0;
        id_rf_ra0 = 5'd0;
        vec("load_use_x0", NONE);

        // Port 1 matches but is not read, then is read.
        idle();
        set_load_use();
        id_rf_ra0 = 5'd3;
        id_rf_ra1 = 5'd5;
        id_re1    = 1'b0;
        vec("load_use_re1_off", NONE);
        id_re1 = 1'b1;
        vec("load_use_ra1", LU);
        id_re0    = 1'b1;
        id_rf_ra0 = 5'd5;
        id_re1    = 1'b0;
        id_rf_ra1 = 5'd0;
        vec("load_use_ra0_again", LU);

        // Non-load write-back and no-write cases.
        ex_rf_wd_sel = 2'b01;
        vec("alu_writeback", NONE);
        ex_rf_wd_sel = 2'b10;
        ex_rf_we     = 1'b0;
        vec("no_write", NONE);

        // Branch wins over coincident load-use.
        set_load_use();
        ex_br_taken = 1'b1;
        vec("branch_over_load_use", BR);
        chk_perf("branch");

        // Disabled block drives nothing.
        global_en = 1'b0;
        vec("disabled_load_use", NONE);
        chk_perf("disabled");

        // dmem wait with a pending branch: stall, then the branch flushes on completion.
        idle();
        ex_br_taken = 1'b1;
        mem_req     = 1'b1;
        for (int i = 0; i < 3; i++) vec("mem_wait_branch", FULL);
        mem_ready = 1'b1;
        vec("mem_ready_branch", BR);
        idle();
        vec("after_branch", NONE);

        // Timeout: counter must have restarted from 0 after the previous wait.
        mem_req = 1'b1;
        for (int i = 0; i < 16; i++) vec("timeout_wait", FULL);
        vec("halt_entered", HLT);
        mem_ready = 1'b1;
        vec("halt_ready", HLT);
        mem_req = 1'b0;
        vec("halt_no_req", HLT);
        chk_perf("halt");

        // Async reset mid-HALT takes effect before the next edge.
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {24'h0, outs}, {24'h0, NONE});
        exp_sc = 0;
        exp_fe = 0;
        chk_perf("async_rst");
        rst = 1'b0;
        idle();
        set_load_use();
        #1;
        chk("run_after_rst", {24'h0, outs}, {24'h0, LU});
        exp_sc++;
        exp_fe++;
        @(posedge clk);
        #1;
        idle();
        vec("idle_after_rst", NONE);
        chk_perf("post_rst");

        // Freeze mid-WAIT; the wait count resumes from its held value.
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) vec("freeze_wait_pre", FULL);
        global_en = 1'b0;
        for (int i = 0; i < 4; i++) vec("freeze_disabled", NONE);
        global_en = 1'b1;
        for (int i = 0; i < 11; i++) vec("freeze_wait_post", FULL);
        vec("freeze_halt", HLT);
        chk_perf("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
